// File: rtl/chk_fill_monitor_pkg.sv
// Shared PCS 25G fill-char constants and the 2-bit lane class encoding
// used by the RX pop-side fill checker.
package chk_fill_monitor_pkg;

  localparam int unsigned PCS_CHAR_W  = 48;
  localparam int unsigned SYNC_CODE_W = 37;
  localparam int unsigned SYNC_PAD_W  = PCS_CHAR_W - SYNC_CODE_W;

  localparam logic [PCS_CHAR_W-1:0]  ESC_CHAR  = 48'h1E1E_1E1E_1E1E;
  localparam logic [PCS_CHAR_W-1:0]  IDLE_CHAR = 48'h0707_0707_0707;
  localparam logic [SYNC_CODE_W-1:0] SYNC_CODE = 37'h1A_5A5A_5A5A;
  // SYNC is the 37-bit code in the upper bits with an all-zero pad below
  localparam logic [PCS_CHAR_W-1:0]  SYNC_CHAR = {SYNC_CODE, SYNC_PAD_W'(0)};

  typedef enum logic [1:0] {
    CLS_ESC  = 2'd0,
    CLS_IDLE = 2'd1,
    CLS_SYNC = 2'd2,
    CLS_BAD  = 2'd3
  } fill_cls_e;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_RUN        = 2'd1,
    ST_TIMEOUT    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/chk_fill_classify.sv
// Combinational classifier: one fill-char lane to its 2-bit class.
module chk_fill_classify
  import chk_fill_monitor_pkg::*;
#(
  parameter int unsigned CHAR_W = 48
) (
  input  logic [CHAR_W-1:0] lane_i,
  output fill_cls_e         cls_c
);

  always_comb begin
    cls_c = CLS_BAD;
    if (lane_i == CHAR_W'(ESC_CHAR)) begin
      cls_c = CLS_ESC;
    end else if (lane_i == CHAR_W'(IDLE_CHAR)) begin
      cls_c = CLS_IDLE;
    end else if (lane_i == CHAR_W'(SYNC_CHAR)) begin
      cls_c = CLS_SYNC;
    end
  end

endmodule

// File: rtl/chk_fill_monitor.sv
// Pop-side fill-char monitor: registered per-word verdict, saturating counters,
// first-error capture and a pop-starvation timeout FSM.
module chk_fill_monitor
  import chk_fill_monitor_pkg::*;
#(
  parameter int unsigned NCHAR   = 4,
  parameter int unsigned CHAR_W  = 48,
  parameter bit          UNIFORM = 1'b1,
  parameter int unsigned TIMEOUT = 10000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pop,
  input  logic [NCHAR*CHAR_W-1:0] data,
  output logic                    correct,
  output logic                    err_sticky,
  output logic                    timeout,
  output logic [CNT_W-1:0]        word_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [NCHAR*CHAR_W-1:0] first_err_data,
  output logic [CNT_W-1:0]        first_err_idx
);

  localparam int unsigned DATA_W = NCHAR * CHAR_W;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam longint unsigned CNT_MAX_L = (64'(1) << CNT_W) - 64'(1);

  if (64'(TIMEOUT) > CNT_MAX_L) begin : g_bad_timeout
    $error("chk_fill_monitor: TIMEOUT does not fit in the CNT_W-bit gap counter");
  end

  fill_cls_e cls [NCHAR];
  logic      word_ok_c;

  for (genvar i = 0; i < NCHAR; i++) begin : g_lane
    chk_fill_classify #(.CHAR_W(CHAR_W)) u_classify (
      .lane_i (data[i*CHAR_W +: CHAR_W]),
      .cls_c  (cls[i])
    );
  end

  // Uniform mode additionally requires every lane to match lane 0
  always_comb begin
    word_ok_c = 1'b1;
    for (int unsigned i = 0; i < NCHAR; i++) begin
      if (cls[i] == CLS_BAD) word_ok_c = 1'b0;
      if (UNIFORM && (cls[i] != cls[0])) word_ok_c = 1'b0;
    end
  end

  mon_state_e             state_q, state_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic                   correct_q, correct_d;
  logic                   sticky_q, sticky_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       ecnt_q, ecnt_d;
  logic [DATA_W-1:0]      cap_data_q, cap_data_d;
  logic [CNT_W-1:0]       cap_idx_q, cap_idx_d;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    correct_d  = !pop || word_ok_c;
    sticky_d   = sticky_q;
    timeout_d  = timeout_q;
    wcnt_d     = wcnt_q;
    ecnt_d     = ecnt_q;
    cap_data_d = cap_data_q;
    cap_idx_d  = cap_idx_q;

    if (pop) begin
      if (wcnt_q != CNT_SAT) wcnt_d = wcnt_q + CNT_W'(1);
      if (!word_ok_c) begin
        if (ecnt_q != CNT_SAT) ecnt_d = ecnt_q + CNT_W'(1);
        if (!sticky_q) begin
          sticky_d   = 1'b1;
          cap_data_d = data;
          cap_idx_d  = wcnt_q;
        end
      end
    end

    // A pop on the expiry cycle wins over the timeout
    case (state_q)
      ST_WAIT_FIRST: begin
        gap_d = '0;
        if (pop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop) begin
          gap_d = '0;
        end else begin
          if (gap_q != CNT_W'(TIMEOUT)) gap_d = gap_q + CNT_W'(1);
          if (gap_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end
        end
      end
      ST_TIMEOUT: begin
        timeout_d = 1'b1;
      end
      default: begin
        state_d = ST_WAIT_FIRST;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_FIRST;
      gap_q      <= '0;
      correct_q  <= 1'b1;
      sticky_q   <= 1'b0;
      timeout_q  <= 1'b0;
      wcnt_q     <= '0;
      ecnt_q     <= '0;
      cap_data_q <= '0;
      cap_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      correct_q  <= correct_d;
      sticky_q   <= sticky_d;
      timeout_q  <= timeout_d;
      wcnt_q     <= wcnt_d;
      ecnt_q     <= ecnt_d;
      cap_data_q <= cap_data_d;
      cap_idx_q  <= cap_idx_d;
    end
  end

  assign correct        = correct_q;
  assign err_sticky     = sticky_q;
  assign timeout        = timeout_q;
  assign word_cnt       = wcnt_q;
  assign err_cnt        = ecnt_q;
  assign first_err_data = cap_data_q;
  assign first_err_idx  = cap_idx_q;

endmodule

// File: tb/tb_chk_fill_monitor.sv
// Directed bench for chk_fill_monitor: vector table plus timeout and saturation sequences.
module tb_chk_fill_monitor;
  import chk_fill_monitor_pkg::*;

  localparam int unsigned DW = 192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instances A (UNIFORM=1) and B (UNIFORM=0) share stimulus; C has CNT_W=4
  logic          a_rst, a_pop;
  logic [DW-1:0] a_data;
  logic          a_corr, a_sticky, a_tmo, b_corr, b_sticky, b_tmo;
  logic [15:0]   a_wcnt, a_ecnt, a_idx, b_wcnt, b_ecnt, b_idx;
  logic [DW-1:0] a_cap, b_cap;

  logic          c_rst, c_pop;
  logic [DW-1:0] c_data, c_cap;
  logic          c_corr, c_sticky, c_tmo;
  logic [3:0]    c_wcnt, c_ecnt, c_idx;

  chk_fill_monitor #(.NCHAR(4), .CHAR_W(48), .UNIFORM(1'b1), .TIMEOUT(16), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(a_rst), .pop(a_pop), .data(a_data), .correct(a_corr),
    .err_sticky(a_sticky), .timeout(a_tmo), .word_cnt(a_wcnt), .err_cnt(a_ecnt),
    .first_err_data(a_cap), .first_err_idx(a_idx));

  chk_fill_monitor #(.NCHAR(4), .CHAR_W(48), .UNIFORM(1'b0), .TIMEOUT(16), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(a_rst), .pop(a_pop), .data(a_data), .correct(b_corr),
    .err_sticky(b_sticky), .timeout(b_tmo), .word_cnt(b_wcnt), .err_cnt(b_ecnt),
    .first_err_data(b_cap), .first_err_idx(b_idx));

  chk_fill_monitor #(.NCHAR(4), .CHAR_W(48), .UNIFORM(1'b1), .TIMEOUT(15), .CNT_W(4)) u_dut_c (
    .clk(clk), .reset(c_rst), .pop(c_pop), .data(c_data), .correct(c_corr),
    .err_sticky(c_sticky), .timeout(c_tmo), .word_cnt(c_wcnt), .err_cnt(c_ecnt),
    .first_err_data(c_cap), .first_err_idx(c_idx));

  typedef struct {
    logic          rst;
    logic          pop;
    logic [DW-1:0] data;
    logic          ex_corr;
    logic          ex_b_corr;
    logic [15:0]   ex_wcnt;
    logic [15:0]   ex_ecnt;
    logic          ex_sticky;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DW-1:0] w_idle, w_esc, w_sync, w_mix, w_badpad, w_bad9;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic pop, input logic [DW-1:0] d,
                              input logic ec, input logic ebc, input int ew, input int ee,
                              input logic es);
    vec_t v;
    v.rst = rst; v.pop = pop; v.data = d; v.ex_corr = ec; v.ex_b_corr = ebc;
    v.ex_wcnt = 16'(ew); v.ex_ecnt = 16'(ee); v.ex_sticky = es;
    return v;
  endfunction

  initial begin
    w_idle   = {4{IDLE_CHAR}};
    w_esc    = {4{ESC_CHAR}};
    w_sync   = {4{SYNC_CHAR}};
    w_mix    = {ESC_CHAR, IDLE_CHAR, IDLE_CHAR, IDLE_CHAR};
    w_badpad = {SYNC_CHAR, SYNC_CHAR, {SYNC_CODE, 11'h001}, SYNC_CHAR};
    w_bad9   = {IDLE_CHAR, 48'h0000_0000_0123, IDLE_CHAR, IDLE_CHAR};

    // Eight clean pops
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, w_idle, 1, 1, i, 0, 0));
    // Reset with a same-cycle pop, then mixed-lane word at index 3
    vecs.push_back(mk(1, 1, w_idle, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 3; i++) vecs.push_back(mk(0, 1, w_idle, 1, 1, i, 0, 0));
    vecs.push_back(mk(0, 1, w_mix, 0, 1, 4, 1, 1));
    vecs.push_back(mk(0, 0, w_mix, 1, 1, 4, 1, 1));

    a_rst = 1; a_pop = 0; a_data = '0;
    c_rst = 1; c_pop = 0; c_data = '0;
    step; step;
    a_rst = 0; c_rst = 0;
    step;
    chk("rst_correct", a_corr, 1);
    chk("rst_sticky", a_sticky, 0);
    chk("rst_timeout", a_tmo, 0);
    chk("rst_wcnt", a_wcnt, 0);
    chk("rst_ecnt", a_ecnt, 0);
    chk("rst_cap", a_cap, 0);
    chk("rst_idx", a_idx, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_rst = vecs[i].rst; a_pop = vecs[i].pop; a_data = vecs[i].data;
      step;
      chk($sformatf("v%0d_correct", i), a_corr, vecs[i].ex_corr);
      chk($sformatf("v%0d_b_correct", i), b_corr, vecs[i].ex_b_corr);
      chk($sformatf("v%0d_wcnt", i), a_wcnt, vecs[i].ex_wcnt);
      chk($sformatf("v%0d_ecnt", i), a_ecnt, vecs[i].ex_ecnt);
      chk($sformatf("v%0d_sticky", i), a_sticky, vecs[i].ex_sticky);
    end
    a_rst = 0; a_pop = 0;
    chk("mix_idx", a_idx, 3);
    chk("mix_cap", a_cap, w_mix);
    chk("mix_b_ecnt", b_ecnt, 0);

    // Bad pad at word 5, different bad word at word 9
    vecs.delete();
    vecs.push_back(mk(1, 0, w_idle, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, w_esc,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, w_sync, 1, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, w_idle, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, w_esc,  1, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, w_sync, 1, 1, 5, 0, 0));
    vecs.push_back(mk(0, 1, w_badpad, 0, 0, 6, 1, 1));
    for (int i = 7; i <= 9; i++) vecs.push_back(mk(0, 1, w_idle, 1, 1, i, 1, 1));
    vecs.push_back(mk(0, 1, w_bad9, 0, 0, 10, 2, 1));
    vecs.push_back(mk(0, 0, w_bad9, 1, 1, 10, 2, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      a_rst = vecs[i].rst; a_pop = vecs[i].pop; a_data = vecs[i].data;
      step;
      chk($sformatf("p%0d_correct", i), a_corr, vecs[i].ex_corr);
      chk($sformatf("p%0d_b_correct", i), b_corr, vecs[i].ex_b_corr);
      chk($sformatf("p%0d_wcnt", i), a_wcnt, vecs[i].ex_wcnt);
      chk($sformatf("p%0d_ecnt", i), a_ecnt, vecs[i].ex_ecnt);
      chk($sformatf("p%0d_sticky", i), a_sticky, vecs[i].ex_sticky);
    end
    a_rst = 0; a_pop = 0;
    chk("keep_idx", a_idx, 5);
    chk("keep_cap", a_cap, w_badpad);

    // Timeout boundary with TIMEOUT=16
    a_rst = 1; step; a_rst = 0;
    a_pop = 1; a_data = w_idle; step; a_pop = 0;
    for (int i = 0; i < 15; i++) step;
    chk("tmo_after15", a_tmo, 0);
    a_pop = 1; step; a_pop = 0;
    chk("tmo_pop_on_16th", a_tmo, 0);
    for (int i = 0; i < 15; i++) step;
    chk("tmo_idle15_again", a_tmo, 0);
    step;
    chk("tmo_idle16", a_tmo, 1);
    a_pop = 1;
    for (int i = 0; i < 3; i++) step;
    a_pop = 0;
    chk("tmo_sticky", a_tmo, 1);
    chk("tmo_wcnt", a_wcnt, 5);
    step;
    chk("tmo_correct", a_corr, 1);

    // No first pop: no timeout
    a_rst = 1; step; a_rst = 0;
    for (int i = 0; i < 48; i++) step;
    chk("wait_first_tmo", a_tmo, 0);
    chk("wait_first_wcnt", a_wcnt, 0);

    // Saturation on the 4-bit instance, then reset with pop high
    c_rst = 1; step; c_rst = 0;
    c_pop = 1; c_data = w_bad9;
    for (int i = 0; i < 20; i++) step;
    chk("sat_wcnt", c_wcnt, 15);
    chk("sat_ecnt", c_ecnt, 15);
    chk("sat_idx", c_idx, 0);
    chk("sat_cap", c_cap, w_bad9);
    chk("sat_correct", c_corr, 0);
    c_rst = 1; step; c_rst = 0; c_pop = 0;
    chk("srst_correct", c_corr, 1);
    chk("srst_sticky", c_sticky, 0);
    chk("srst_timeout", c_tmo, 0);
    chk("srst_wcnt", c_wcnt, 0);
    chk("srst_ecnt", c_ecnt, 0);
    chk("srst_cap", c_cap, 0);
    chk("srst_idx", c_idx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
